lsu_mem_access: RTL

- Memory-stage load/store access unit for the AXI MIPS core; successor to the combinational load/store alignment checker.
- Accepts one load/store per transaction from the M stage and checks alignment for byte, half, word and (when DATA_W=64) double sizes.
- Raises registered load/store address-error flags with BadVAddr capture. Aligned accesses are issued on the SRAM-like data port that feeds the AXI bridge.
- Stalls the pipeline until the response returns, then delivers sign- or zero-extended load data. Supports flush/cancel of in-flight accesses.

---
 rtl/lsu_mem_access_if.sv | 53 +++++
 rtl/lsu_mem_access.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access_if.sv
// Handshake bundle between the M stage, the load/store unit and the SRAM-like
// data port that feeds the AXI bridge.
//   req_*  / flush      : M-stage request side (driven by the pipeline)
//   resp_* / *addrerr   : completion and exception reporting back to the pipeline
//   data_*              : SRAM-like bus toward the AXI bridge
// Modports:
//   master : pipeline + bus environment (drives requests and bus responses)
//   slave  : the load/store unit itself
interface lsu_mem_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [STRB_W-1:0] data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              laddrerr;
  logic              saddrerr;
  logic [ADDR_W-1:0] badvaddr;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, flush,
    output data_addr_ok, data_data_ok, data_rdata,
    input  req_ready, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  resp_valid, resp_rdata, laddrerr, saddrerr, badvaddr
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, flush,
    input  data_addr_ok, data_data_ok, data_rdata,
    output req_ready, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output resp_valid, resp_rdata, laddrerr, saddrerr, badvaddr
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Memory-stage load/store access unit.
// Accepts one load/store at a time from the M stage, checks alignment, reports
// misaligned accesses as registered address-error pulses with BadVAddr capture,
// and issues aligned accesses on the SRAM-like data port. The pipeline is
// stalled (req_ready low) until the access completes; loads return sign- or
// zero-extended data. A flush cancels the in-flight access without withdrawing
// the bus request.
// Ports:
//   clk    : core clock
//   resetn : asynchronous active-low reset
//   io     : request/response/bus bundle (slave view)
module lsu_mem_access #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  lsu_mem_access_if.slave io
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state;
  logic              cancel;
  logic              lat_unsigned;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [STRB_W-1:0] data_wstrb;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              laddrerr;
  logic              saddrerr;
  logic [ADDR_W-1:0] badvaddr;

  // Alignment check on the incoming request; double is never legal on a 32-bit bus.
  logic misaligned;
  always_comb begin
    case (io.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = io.req_addr[0];
      2'd2:    misaligned = |io.req_addr[1:0];
      default: misaligned = (DATA_W == 32) || (|io.req_addr[2:0]);
    endcase
  end

  // Store lane replication and byte enables, computed from the live request
  // so the latched bus copy is ready the cycle after acceptance.
  logic [OFF_W-1:0]  req_off;
  logic [STRB_W-1:0] base_strb;
  logic [STRB_W-1:0] st_wstrb;
  logic [DATA_W-1:0] st_wdata;

  assign req_off = io.req_addr[OFF_W-1:0];

  always_comb begin
    base_strb = '0;
    st_wdata  = io.req_wdata;
    case (io.req_size)
      2'd0: begin
        base_strb[0]   = 1'b1;
        st_wdata       = {STRB_W{io.req_wdata[7:0]}};
      end
      2'd1: begin
        base_strb[1:0] = '1;
        st_wdata       = {(STRB_W/2){io.req_wdata[15:0]}};
      end
      2'd2: begin
        base_strb[3:0] = '1;
        st_wdata       = {(DATA_W/32){io.req_wdata[31:0]}};
      end
      default: base_strb = '1;
    endcase
    st_wstrb = base_strb << req_off;
    if (!io.req_we) begin
      st_wdata = '0;
      st_wstrb = '0;
    end
  end

  // Load result: move the addressed bytes down to bit 0, then extend.
  // Extension fills the whole word first and overwrites the low field, which
  // keeps the same code valid for both bus widths.
  logic [OFF_W-1:0]  rsp_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_data;

  assign rsp_off = data_addr[OFF_W-1:0];
  assign shifted = io.data_rdata >> {rsp_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (data_size)
      2'd0: begin
        ld_data        = (shifted[7] && !lat_unsigned) ? '1 : '0;
        ld_data[7:0]   = shifted[7:0];
      end
      2'd1: begin
        ld_data        = (shifted[15] && !lat_unsigned) ? '1 : '0;
        ld_data[15:0]  = shifted[15:0];
      end
      2'd2: begin
        ld_data        = (shifted[31] && !lat_unsigned) ? '1 : '0;
        ld_data[31:0]  = shifted[31:0];
      end
      default: ld_data = shifted;
    endcase
    if (data_wr) begin
      ld_data = '0;
    end
  end

  // A flush arriving in the same cycle as data_ok cancels just like an earlier one.
  logic cancel_now;
  assign cancel_now = cancel || io.flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cancel       <= 1'b0;
      lat_unsigned <= 1'b0;
      data_req     <= 1'b0;
      data_wr      <= 1'b0;
      data_size    <= '0;
      data_addr    <= '0;
      data_wdata   <= '0;
      data_wstrb   <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      laddrerr     <= 1'b0;
      saddrerr     <= 1'b0;
      badvaddr     <= '0;
    end else begin
      resp_valid <= 1'b0;
      laddrerr   <= 1'b0;
      saddrerr   <= 1'b0;
      case (state)
        IDLE: begin
          if (io.req_valid && !io.flush) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              laddrerr   <= !io.req_we;
              saddrerr   <= io.req_we;
              badvaddr   <= io.req_addr;
              resp_rdata <= '0;
            end else begin
              data_req     <= 1'b1;
              data_wr      <= io.req_we;
              data_size    <= io.req_size;
              data_addr    <= io.req_addr;
              data_wdata   <= st_wdata;
              data_wstrb   <= st_wstrb;
              lat_unsigned <= io.req_unsigned;
              cancel       <= 1'b0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (io.flush) begin
            cancel <= 1'b1;
          end
          if (io.data_addr_ok) begin
            data_req <= 1'b0;
            if (io.data_data_ok) begin
              if (cancel_now) begin
                cancel <= 1'b0;
                state  <= IDLE;
              end else begin
                resp_rdata <= ld_data;
                state      <= RESP;
              end
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (io.flush) begin
            cancel <= 1'b1;
          end
          if (io.data_data_ok) begin
            if (cancel_now) begin
              cancel <= 1'b0;
              state  <= IDLE;
            end else begin
              resp_rdata <= ld_data;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          resp_valid <= !io.flush;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.req_ready  = (state == IDLE);
  assign io.data_req   = data_req;
  assign io.data_wr    = data_wr;
  assign io.data_size  = data_size;
  assign io.data_addr  = data_addr;
  assign io.data_wdata = data_wdata;
  assign io.data_wstrb = data_wstrb;
  assign io.resp_valid = resp_valid;
  assign io.resp_rdata = resp_rdata;
  assign io.laddrerr   = laddrerr;
  assign io.saddrerr   = saddrerr;
  assign io.badvaddr   = badvaddr;
endmodule
